tta_bundle_decoder: RTL and testbench
=====================================

// Module: tta_bundle_decoder
// PURPOSE
//  Parametrised successor to decodeunit: decodes a bundle of SLOTS move/literal slots per
//  instruction word. Sits between fetch and the transport bus.
//  Adds valid/ready handshaking on both sides, a 2-entry skid buffer, NOP suppression,
//  same-bundle destination conflict detection and per-slot high/low literal merging.
// PARAMETERS
//  SLOTS   2   move slots per bundle
//  ADDR_W  7   socket/register address width (src, dest)
//  LIT_W   12  literal field width; merged immediate is 2*LIT_W
//  (derived) SLOT_W = 2+ADDR_W+LIT_W (21); INSTR_W = SLOTS*SLOT_W; slot i = instr[i*SLOT_W +: SLOT_W]
// PORTS
//  clk           in   1                 clock, all state on rising edge
//  rst           in   1                 synchronous, active-high reset
//  in_valid      in   1                 bundle on instr is valid
//  in_ready      out  1                 decoder can accept a bundle this cycle
//  instr         in   INSTR_W           bundle
//  out_valid     out  1                 decoded bundle valid
//  out_ready     in   1                 consumer accepts decoded bundle
//  out_slot_vld  out  SLOTS             per-slot: slot carries a real op (not NOP, not conflict-killed)
//  out_lit_mv    out  SLOTS             1 = literal load, 0 = move
//  out_hl        out  SLOTS             literal half: 1 = high, 0 = low
//  out_src       out  SLOTS*ADDR_W      move source (0 for literals)
//  out_dest      out  SLOTS*ADDR_W      destination
//  out_imm       out  SLOTS*2*LIT_W     merged immediate (0 for moves)
//  out_conflict  out  1                 two or more valid slots in this bundle target the same dest
// BEHAVIOUR
//  - Slot format, MSB to LSB: lit_mv[SLOT_W-1], hl[SLOT_W-2], dest[LIT_W+:ADDR_W], payload[LIT_W-1:0].
//    Move: src = payload[LIT_W-1 -: ADDR_W]. Literal: lit = payload.
//  - NOP: lit_mv=0, dest=0, src=0. A NOP slot yields out_slot_vld=0 and all of its other fields 0.
//  - Conflict: if valid slots i<j share a dest, the lower slot i is cleared (highest index wins)
//    and out_conflict=1. With three or more slots on one dest, only the highest survives.
//  - Literal merge uses per-slot prefix registers pfx[i]/pfx_v[i]; they update only on input acceptance.
//    hl=1: pfx[i]<=lit, pfx_v[i]<=1; out_imm_i = {lit, LIT_W'b0}.
//    hl=0: out_imm_i = {pfx_v[i] ? pfx[i] : 0, lit}; pfx_v[i]<=0.
//    A conflict-killed or NOP slot does not touch pfx.
//  - Handshake: accept = in_valid & in_ready; emit = out_valid & out_ready. instr is sampled only on accept.
//    Outputs are held stable while out_valid & !out_ready.
//  - Latency: 1 cycle (accept in cycle N -> out_valid in N+1 when the output stage is empty).
//    Steady-state throughput: 1 bundle/cycle.
//  - Buffering: output register + 1 skid entry. in_ready = !skid_full & !rst (registered-source, no
//    combinational path from out_ready). Order is preserved; no loss or duplication.
//  - Simultaneous accept and emit with the skid full: the skid drains to the output register first.
//    The new bundle is then accepted only if in_ready was high in that cycle.
//  - Reset (any cycle, including mid-stream): clears out_valid, skid, all pfx_v and all outputs to 0.
//    in_ready=0 while rst=1 and 1 in the first cycle after.
// STRUCTURE
//  - Shared header tta_defs.vh: slot field offsets/width macros, NOP encoding, lit_mv/hl bit positions.
//    decodeunit uses the same header.
//  - One sub-module, tta_skid_buffer #(W): generic 2-entry valid/ready skid carrying the decoded
//    bundle plus the conflict flag.
//  - Decode, NOP and conflict logic are combinational before the skid; the pfx registers live in
//    the top module.
// TESTING (SLOTS=2, ADDR_W=7, LIT_W=12; bundle = {slot1, slot0})
//  1 Reset 3 cycles, then {NOP, 21'h07F020} -> next cycle out_valid=1; slot0 vld, src=1, dest=7F,
//    lit_mv=0; out_slot_vld[1]=0.
//  2 Slot0 21'h180FFF, then slot0 21'h100ABC -> out_imm slot0 = 24'hFFF000, then 24'hFFFABC;
//    a third hl=0 ABC -> 24'h000ABC.
//  3 Slot0 and slot1 both move to dest 05 -> out_conflict=1, out_slot_vld=2'b10, slot0 fields 0.
//  4 Hold out_ready=0 and offer 3 bundles -> 2 accepted, in_ready=0. Then out_ready=1 -> 3 emitted
//    in order, none lost or duplicated.
//  5 After 21'h180FFF, pulse rst for 1 cycle -> out_valid=0, outputs 0.
//    Then slot0 21'h100123 -> imm 24'h000123.
//  6 Random in_valid/out_ready over 10k bundles against a scoreboard model -> exact match;
//    1/cycle when both are held high.

Source files
------------

// File: rtl/tta_bundle_decoder_pkg.sv
// Shared definitions for the TTA bundle decoder: default geometry, slot field
// positions and the skid buffer state encoding.
package tta_bundle_decoder_pkg;

  localparam int DEF_SLOTS  = 2;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_LIT_W  = 12;

  // Slot layout, MSB to LSB: lit_mv, hl, dest, payload.
  function automatic int slot_width(input int addr_w, input int lit_w);
    return 2 + addr_w + lit_w;
  endfunction

  function automatic int lit_mv_bit(input int slot_w);
    return slot_w - 1;
  endfunction

  function automatic int hl_bit(input int slot_w);
    return slot_w - 2;
  endfunction

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/tta_skid_buffer.sv
// Generic 2-entry valid/ready buffer: an output register plus one skid entry.
// in_ready depends only on local state and rst, never on out_ready.
module tta_skid_buffer
  import tta_bundle_decoder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state, state_next;
  logic [W-1:0] skid_data;
  logic         accept, emit;
  logic         load_out, load_skid, from_skid;

  assign in_ready  = (state != SKID_FULL) && !rst;
  assign out_valid = (state != SKID_EMPTY);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    from_skid  = 1'b0;
    unique case (state)
      SKID_EMPTY: begin
        if (accept) begin
          load_out   = 1'b1;
          state_next = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (emit && accept) begin
          load_out = 1'b1;
        end else if (emit) begin
          state_next = SKID_EMPTY;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = SKID_FULL;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so only the drain into the output register can happen.
        if (emit) begin
          load_out   = 1'b1;
          from_skid  = 1'b1;
          state_next = SKID_ONE;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SKID_EMPTY;
      out_data <= '0;
    end else begin
      state <= state_next;
      if (load_out) out_data <= from_skid ? skid_data : in_data;
    end
  end

  // NOTE: the skid entry is not reset; it is only ever read while state says it holds data.
  always_ff @(posedge clk) begin
    if (load_skid) skid_data <= in_data;
  end

endmodule

// File: rtl/tta_bundle_decoder.sv
// Decodes a bundle of SLOTS move/literal slots: NOP suppression, same-bundle
// destination conflict resolution (highest slot wins) and high/low literal merging.
module tta_bundle_decoder
  import tta_bundle_decoder_pkg::*;
#(
  parameter int SLOTS  = DEF_SLOTS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LIT_W  = DEF_LIT_W,
  localparam int SLOT_W  = slot_width(ADDR_W, LIT_W),
  localparam int INSTR_W = SLOTS * SLOT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_W-1:0]        instr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLOTS-1:0]          out_slot_vld,
  output logic [SLOTS-1:0]          out_lit_mv,
  output logic [SLOTS-1:0]          out_hl,
  output logic [SLOTS*ADDR_W-1:0]   out_src,
  output logic [SLOTS*ADDR_W-1:0]   out_dest,
  output logic [SLOTS*2*LIT_W-1:0]  out_imm,
  output logic                      out_conflict
);

  localparam int LM_BIT   = lit_mv_bit(SLOT_W);
  localparam int HL_BIT   = hl_bit(SLOT_W);
  localparam int IMM_W    = 2 * LIT_W;
  localparam int BUNDLE_W = 1 + 3*SLOTS + 2*SLOTS*ADDR_W + SLOTS*IMM_W;

  logic [SLOTS-1:0]        f_lm, f_hl, live, kill;
  logic [ADDR_W-1:0]       f_dest [SLOTS];
  logic [ADDR_W-1:0]       f_src  [SLOTS];
  logic [LIT_W-1:0]        f_lit  [SLOTS];

  logic [SLOTS-1:0]        d_vld, d_lm, d_hl;
  logic [SLOTS*ADDR_W-1:0] d_src, d_dest;
  logic [SLOTS*IMM_W-1:0]  d_imm;
  logic                    d_conflict;

  logic [LIT_W-1:0]        pfx [SLOTS];
  logic [SLOTS-1:0]        pfx_v;
  logic                    accept;
  logic [BUNDLE_W-1:0]     out_bundle;

  assign accept = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      f_lm[i]   = instr[i*SLOT_W + LM_BIT];
      f_hl[i]   = instr[i*SLOT_W + HL_BIT];
      f_dest[i] = instr[i*SLOT_W + LIT_W +: ADDR_W];
      f_lit[i]  = instr[i*SLOT_W +: LIT_W];
      f_src[i]  = f_lit[i][LIT_W-1 -: ADDR_W];
      live[i]   = f_lm[i] | (|f_dest[i]) | (|f_src[i]);
    end
  end

  // A live slot is killed when any later live slot writes the same destination.
  always_comb begin
    kill = '0;
    for (int i = 0; i < SLOTS; i++) begin
      for (int j = i + 1; j < SLOTS; j++) begin
        if (live[i] && live[j] && (f_dest[i] == f_dest[j])) kill[i] = 1'b1;
      end
    end
  end

  // Dropped slots and the fields a slot kind does not use are all driven to zero.
  always_comb begin
    d_vld      = '0;
    d_lm       = '0;
    d_hl       = '0;
    d_src      = '0;
    d_dest     = '0;
    d_imm      = '0;
    d_conflict = |(live & kill);
    for (int i = 0; i < SLOTS; i++) begin
      d_vld[i] = live[i] & ~kill[i];
      if (d_vld[i]) begin
        d_lm[i]                       = f_lm[i];
        d_dest[i*ADDR_W +: ADDR_W]    = f_dest[i];
        if (f_lm[i]) begin
          d_hl[i] = f_hl[i];
          d_imm[i*IMM_W +: IMM_W] = f_hl[i] ? {f_lit[i], {LIT_W{1'b0}}}
                                            : {(pfx_v[i] ? pfx[i] : {LIT_W{1'b0}}), f_lit[i]};
        end else begin
          d_src[i*ADDR_W +: ADDR_W] = f_src[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pfx_v <= '0;
    end else if (accept) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (d_vld[i] && f_lm[i]) pfx_v[i] <= f_hl[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (d_vld[i] && f_lm[i] && f_hl[i]) pfx[i] <= f_lit[i];
      end
    end
  end

  tta_skid_buffer #(.W(BUNDLE_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({d_conflict, d_vld, d_lm, d_hl, d_src, d_dest, d_imm}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bundle)
  );

  assign {out_conflict, out_slot_vld, out_lit_mv, out_hl, out_src, out_dest, out_imm} = out_bundle;

endmodule

// File: tb/tb_tta_bundle_decoder.sv
// Self-checking bench for tta_bundle_decoder (SLOTS=2, ADDR_W=7, LIT_W=12):
// directed vector table, hand-written handshake/reset sequences, randomized scoreboard run.
module tb_tta_bundle_decoder;

  localparam int SLOTS  = 2;
  localparam int ADDR_W = 7;
  localparam int LIT_W  = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [41:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_slot_vld, out_lit_mv, out_hl;
  logic [13:0] out_src, out_dest;
  logic [47:0] out_imm;
  logic        out_conflict;

  always #5 clk = ~clk;

  tta_bundle_decoder #(.SLOTS(SLOTS), .ADDR_W(ADDR_W), .LIT_W(LIT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_slot_vld (out_slot_vld),
    .out_lit_mv   (out_lit_mv),
    .out_hl       (out_hl),
    .out_src      (out_src),
    .out_dest     (out_dest),
    .out_imm      (out_imm),
    .out_conflict (out_conflict)
  );

  typedef struct packed {
    logic        conflict;
    logic [1:0]  vld;
    logic [1:0]  lm;
    logic [1:0]  hl;
    logic [13:0] src;
    logic [13:0] dest;
    logic [47:0] imm;
  } dec_t;

  typedef struct {
    logic [41:0] instr;
    dec_t        exp;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  dec_t sb_q[$];
  int   n_acc, n_emit;
  int   m_pfx   [2];
  bit   m_pfx_v [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic dec_t got_bundle();
    return {out_conflict, out_slot_vld, out_lit_mv, out_hl, out_src, out_dest, out_imm};
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_pfx[s]   = 0;
      m_pfx_v[s] = 1'b0;
    end
  endfunction

  // Reference decode from the slot rules, with the literal-prefix history kept in m_pfx.
  function automatic dec_t model(input logic [41:0] b);
    dec_t e;
    int   lm [2], hl [2], dst [2], lit [2], src [2];
    bit   live [2], keep [2];
    e = '0;
    for (int s = 0; s < 2; s++) begin
      int w;
      w       = int'((b >> (21 * s)) & 42'h1FFFFF);
      lm[s]   = (w >> 20) & 1;
      hl[s]   = (w >> 19) & 1;
      dst[s]  = (w >> 12) & 127;
      lit[s]  = w & 4095;
      src[s]  = lit[s] / 32;
      live[s] = !(lm[s] == 0 && dst[s] == 0 && src[s] == 0);
    end
    for (int s = 0; s < 2; s++) begin
      keep[s] = live[s];
      for (int t = s + 1; t < 2; t++)
        if (live[t] && dst[t] == dst[s]) keep[s] = 1'b0;
      if (live[s] && !keep[s]) e.conflict = 1'b1;
    end
    for (int s = 0; s < 2; s++) begin
      if (keep[s]) begin
        e.vld[s]         = 1'b1;
        e.dest[7*s +: 7] = 7'(dst[s]);
        if (lm[s] == 1) begin
          e.lm[s] = 1'b1;
          e.hl[s] = hl[s][0];
          if (hl[s] == 1) begin
            e.imm[24*s +: 24] = 24'(lit[s] * 4096);
            m_pfx[s]   = lit[s];
            m_pfx_v[s] = 1'b1;
          end else begin
            e.imm[24*s +: 24] = 24'((m_pfx_v[s] ? m_pfx[s] : 0) * 4096 + lit[s]);
            m_pfx_v[s] = 1'b0;
          end
        end else begin
          e.src[7*s +: 7] = 7'(src[s]);
        end
      end
    end
    return e;
  endfunction

  function automatic logic [20:0] rand_slot();
    logic [20:0] s;
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0:       s = '0;
      1:       s = {2'b00, 7'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), 5'($urandom)};
      default: s = {1'b1, 1'($urandom), 7'($urandom_range(0, 3)), 12'($urandom)};
    endcase
    return s;
  endfunction

  function automatic vec_t mkv(input logic [41:0] ins, input logic c, input logic [1:0] v,
                               input logic [1:0] lm, input logic [1:0] hl, input logic [13:0] s,
                               input logic [13:0] d, input logic [47:0] im);
    vec_t r;
    r.instr = ins;
    r.exp   = {c, v, lm, hl, s, d, im};
    return r;
  endfunction

  // One handshake cycle checked against the scoreboard; samples on the falling edge.
  task automatic run_cycle(input bit v, input bit r, input logic [41:0] ins);
    bit acc, em;
    in_valid  = v;
    out_ready = r;
    instr     = ins;
    @(negedge clk);
    acc = in_valid && in_ready;
    em  = out_valid && out_ready;
    if (em) begin
      if (sb_q.size() == 0) check("sb_underflow", 1, 0);
      else check("sb_bundle", got_bundle(), sb_q.pop_front());
      n_emit++;
    end
    if (acc) begin
      sb_q.push_back(model(instr));
      n_acc++;
    end
    tick();
  endtask

  vec_t vecs [10];
  dec_t ea, eb, ec;
  int   a0, e0;

  initial begin
    vecs[0] = mkv({21'h0, 21'h07F020},        0, 2'b01, 2'b00, 2'b00, 14'h0001, 14'h007F, 48'h0);
    vecs[1] = mkv({21'h0, 21'h180FFF},        0, 2'b01, 2'b01, 2'b01, 14'h0, 14'h0, 48'h000000_FFF000);
    vecs[2] = mkv({21'h0, 21'h100ABC},        0, 2'b01, 2'b01, 2'b00, 14'h0, 14'h0, 48'h000000_FFFABC);
    vecs[3] = mkv({21'h0, 21'h100ABC},        0, 2'b01, 2'b01, 2'b00, 14'h0, 14'h0, 48'h000000_000ABC);
    vecs[4] = mkv({21'h005120, 21'h005060},   1, 2'b10, 2'b00, 2'b00, {7'd9, 7'd0}, {7'd5, 7'd0}, 48'h0);
    vecs[5] = mkv({21'h180ABC, 21'h010040},   0, 2'b11, 2'b10, 2'b10, {7'd0, 7'd2}, {7'd0, 7'h10},
                  {24'hABC000, 24'h0});
    vecs[6] = mkv({21'h100001, 21'h0},        0, 2'b10, 2'b10, 2'b00, 14'h0, 14'h0, {24'hABC001, 24'h0});
    vecs[7] = mkv({21'h100222, 21'h180777},   1, 2'b10, 2'b10, 2'b00, 14'h0, 14'h0, {24'h000222, 24'h0});
    vecs[8] = mkv({21'h0, 21'h100555},        0, 2'b01, 2'b01, 2'b00, 14'h0, 14'h0, 48'h000000_000555);
    vecs[9] = mkv(42'h0,                      0, 2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 48'h0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instr = '0;
    model_reset();
    repeat (3) tick();
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", got_bundle(), 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // Directed table: one bundle per cycle, consumer always ready.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      instr    = vecs[i].instr;
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_out_valid", i), out_valid, 1);
      check($sformatf("vec%0d_fields", i), got_bundle(), vecs[i].exp);
    end
    tick();
    check("table_drained", out_valid, 0);

    // Backpressure: three bundles offered while the consumer stalls.
    ea = model({21'h0, 21'h001020});
    eb = model({21'h0, 21'h002040});
    ec = model({21'h0, 21'h003060});
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = {21'h0, 21'h001020};
    tick();
    instr = {21'h0, 21'h002040};
    tick();
    check("skid_full_in_ready", in_ready, 0);
    instr = {21'h0, 21'h003060};
    tick();
    tick();
    check("stall_out_valid", out_valid, 1);
    check("stall_hold_a", got_bundle(), ea);
    out_ready = 1'b1;
    tick();
    check("drain_out_b", got_bundle(), eb);
    check("drain_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("drain_out_c", got_bundle(), ec);
    check("drain_c_valid", out_valid, 1);
    tick();
    check("drain_empty", out_valid, 0);

    // Mid-stream reset clears outputs and the literal prefix.
    in_valid = 1'b1;
    instr    = {21'h0, 21'h180FFF};
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_in_ready_low", in_ready, 0);
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outputs", got_bundle(), 0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    in_valid = 1'b1;
    instr    = {21'h0, 21'h100123};
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_imm", out_imm, 48'h000000_000123);
    tick();

    // Randomized traffic against the scoreboard.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    sb_q.delete();
    n_acc  = 0;
    n_emit = 0;
    for (int c = 0; c < 40000 && n_emit < 10000; c++)
      run_cycle(($urandom % 10) < 7, ($urandom % 10) < 7, {rand_slot(), rand_slot()});
    check("random_emit_count", n_emit >= 10000, 1);
    for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b1, '0);
    check("random_drained", sb_q.size(), 0);

    // Throughput with both sides held high.
    a0 = n_acc;
    e0 = n_emit;
    for (int c = 0; c < 50; c++) run_cycle(1'b1, 1'b1, {rand_slot(), rand_slot()});
    check("stream_accepts", n_acc - a0, 50);
    check("stream_emits", n_emit - e0, 49);
    for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b1, '0);
    check("stream_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
